// File: rtl/bch_dvb_bbh_pkg.sv
// Shared types and constants for the DVB-S2 BBHEADER unpacker.
// The CRC-8 step is MSB-first over the serial header bits.
package bch_dvb_bbh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } state_t;

  localparam int cBBH_BITS   = 80;
  localparam int cMATYPE_OFS = 0;
  localparam int cUPL_OFS    = 16;
  localparam int cDFL_OFS    = 32;
  localparam int cSYNC_OFS   = 48;
  localparam int cSYNCD_OFS  = 56;
  localparam int cCRC_OFS    = 72;

  localparam logic [7:0] cCRC8_POLY = 8'hD5;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic dat);
    logic fb;
    fb = crc[7] ^ dat;
    return {crc[6:0], 1'b0} ^ (fb ? cCRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/bch_dvb_crc8_serial.sv
// Bit-serial CRC-8; init restarts from zero and folds in the current bit.
module bch_dvb_crc8_serial
  import bch_dvb_bbh_pkg::*;
(
  input  logic       iclk,
  input  logic       ireset,
  input  logic       iclkena,
  input  logic       init,
  input  logic       val,
  input  logic       dat,
  output logic [7:0] crc
);

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      crc <= 8'h00;
    end else if (iclkena && val) begin
      crc <= crc8_step(init ? 8'h00 : crc, dat);
    end
  end

endmodule

// File: rtl/bch_dvb_bbh_unpack.sv
// Parses the serial BBHEADER, checks its CRC-8 and packs the DFL data field
// MSB-first into bytes; frame status is reported with ofrm_done.
//
// state | meaning
// IDLE  | waiting for isop
// HDR   | shifting in the 80 header bits
// DATA  | packing DFL bits into bytes
// PAD   | discarding padding until ieop
module bch_dvb_bbh_unpack
  import bch_dvb_bbh_pkg::*;
#(
  parameter int pTAG_W = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              isop,
  input  logic              ival,
  input  logic              ieop,
  input  logic [pTAG_W-1:0] itag,
  input  logic              idat,
  input  logic              idecfail,
  input  logic [15:0]       ibiterr,
  output logic              osop,
  output logic              oval,
  output logic              oeop,
  output logic [7:0]        odat,
  output logic [pTAG_W-1:0] otag,
  output logic              ohdr_val,
  output logic [15:0]       omatype,
  output logic [15:0]       oupl,
  output logic [15:0]       odfl,
  output logic [15:0]       osyncd,
  output logic [7:0]        osync,
  output logic              ohdr_err,
  output logic              ofrm_done,
  output logic              odecfail,
  output logic [15:0]       obiterr,
  output logic              olen_err
);

  state_t      state;
  logic [78:0] hdr_sr;
  logic [6:0]  hdr_cnt;
  logic [15:0] dfl;
  logic [15:0] data_cnt;
  logic [7:0]  pack;
  logic [2:0]  bcnt;
  logic        first;

  logic [79:0] hdr_full;
  logic [15:0] hdr_dfl;
  logic [7:0]  crc;
  logic        crc_ok;
  logic        crc_val;
  logic        data_last;
  logic [7:0]  pack_nxt;

  assign hdr_full  = {hdr_sr, idat};
  assign hdr_dfl   = hdr_full[cBBH_BITS-1-cDFL_OFS -: 16];
  assign crc_ok    = (crc == hdr_full[cBBH_BITS-1-cCRC_OFS -: 8]);
  assign data_last = (data_cnt == dfl - 16'd1);
  // CRC covers header bits 0..71 only; it then holds for the compare at bit 79
  assign crc_val   = ival & (isop | ((state == ST_HDR) & (hdr_cnt < 7'(cCRC_OFS))));

  always_comb begin
    pack_nxt        = pack;
    pack_nxt[~bcnt] = idat;
  end

  bch_dvb_crc8_serial u_crc (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .init    (isop),
    .val     (crc_val),
    .dat     (idat),
    .crc     (crc)
  );

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state     <= ST_IDLE;
      hdr_sr    <= '0;
      hdr_cnt   <= '0;
      dfl       <= '0;
      data_cnt  <= '0;
      pack      <= '0;
      bcnt      <= '0;
      first     <= 1'b0;
      osop      <= 1'b0;
      oval      <= 1'b0;
      oeop      <= 1'b0;
      odat      <= '0;
      otag      <= '0;
      ohdr_val  <= 1'b0;
      omatype   <= '0;
      oupl      <= '0;
      odfl      <= '0;
      osyncd    <= '0;
      osync     <= '0;
      ohdr_err  <= 1'b0;
      ofrm_done <= 1'b0;
      odecfail  <= 1'b0;
      obiterr   <= '0;
      olen_err  <= 1'b0;
    end else if (iclkena) begin
      oval      <= 1'b0;
      osop      <= 1'b0;
      oeop      <= 1'b0;
      ohdr_val  <= 1'b0;
      ofrm_done <= 1'b0;
      if (ival) begin
        if (isop) begin
          // a new frame start closes any open byte stream of the old frame
          if (state == ST_DATA) begin
            odat <= pack;
            oval <= 1'b1;
            osop <= first;
            oeop <= 1'b1;
          end
          otag    <= itag;
          hdr_sr  <= {78'd0, idat};
          hdr_cnt <= 7'd1;
          pack    <= '0;
          bcnt    <= '0;
          if (ieop) begin
            state     <= ST_IDLE;
            ofrm_done <= 1'b1;
            olen_err  <= 1'b1;
            odecfail  <= idecfail;
            obiterr   <= ibiterr;
          end else begin
            state <= ST_HDR;
            if (state != ST_IDLE) begin
              ofrm_done <= 1'b1;
              olen_err  <= 1'b1;
              odecfail  <= 1'b0;
              obiterr   <= '0;
            end
          end
        end else begin
          case (state)
            ST_HDR: begin
              hdr_sr  <= hdr_full[78:0];
              hdr_cnt <= hdr_cnt + 7'd1;
              if (hdr_cnt == 7'(cBBH_BITS-1)) begin
                ohdr_val <= 1'b1;
                ohdr_err <= ~crc_ok;
                omatype  <= hdr_full[cBBH_BITS-1-cMATYPE_OFS -: 16];
                oupl     <= hdr_full[cBBH_BITS-1-cUPL_OFS -: 16];
                odfl     <= hdr_dfl;
                osync    <= hdr_full[cBBH_BITS-1-cSYNC_OFS -: 8];
                osyncd   <= hdr_full[cBBH_BITS-1-cSYNCD_OFS -: 16];
                dfl      <= hdr_dfl;
                data_cnt <= '0;
                first    <= 1'b1;
                pack     <= '0;
                bcnt     <= '0;
                state    <= (crc_ok && hdr_dfl != 16'd0) ? ST_DATA : ST_PAD;
              end
              if (ieop) begin
                state     <= ST_IDLE;
                ofrm_done <= 1'b1;
                olen_err  <= 1'b1;
                odecfail  <= idecfail;
                obiterr   <= ibiterr;
              end
            end
            ST_DATA: begin
              data_cnt <= data_cnt + 16'd1;
              if (bcnt == 3'd7 || data_last || ieop) begin
                odat  <= pack_nxt;
                oval  <= 1'b1;
                osop  <= first;
                oeop  <= data_last | ieop;
                first <= 1'b0;
                pack  <= '0;
                bcnt  <= '0;
              end else begin
                pack <= pack_nxt;
                bcnt <= bcnt + 3'd1;
              end
              if (ieop) begin
                state     <= ST_IDLE;
                ofrm_done <= 1'b1;
                olen_err  <= ~data_last;
                odecfail  <= idecfail;
                obiterr   <= ibiterr;
              end else if (data_last) begin
                state <= ST_PAD;
              end
            end
            ST_PAD: begin
              if (ieop) begin
                state     <= ST_IDLE;
                ofrm_done <= 1'b1;
                olen_err  <= 1'b0;
                odecfail  <= idecfail;
                obiterr   <= ibiterr;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bch_dvb_bbh_unpack.sv
// Directed bench for bch_dvb_bbh_unpack: frames built from field values with
// a reference CRC-8, outputs captured by a monitor and checked against constants.
module tb_bch_dvb_bbh_unpack;

  localparam int TW = 4;

  logic          iclk = 1'b0;
  logic          ireset, iclkena, isop, ival, ieop, idat, idecfail;
  logic [TW-1:0] itag;
  logic [15:0]   ibiterr;
  logic          osop, oval, oeop, ohdr_val, ohdr_err, ofrm_done, odecfail, olen_err;
  logic [7:0]    odat, osync;
  logic [TW-1:0] otag;
  logic [15:0]   omatype, oupl, odfl, osyncd, obiterr;

  int n_assert = 0;
  int n_fail   = 0;
  bit gaps     = 1'b0;

  logic        upd = 1'b0;
  logic [9:0]  bq[$];
  logic [17:0] fq[$];
  int          hdr_n = 0;
  logic [72:0] hdr_cap;

  bch_dvb_bbh_unpack #(.pTAG_W(TW)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
    .ieop(ieop), .itag(itag), .idat(idat), .idecfail(idecfail), .ibiterr(ibiterr),
    .osop(osop), .oval(oval), .oeop(oeop), .odat(odat), .otag(otag),
    .ohdr_val(ohdr_val), .omatype(omatype), .oupl(oupl), .odfl(odfl),
    .osyncd(osyncd), .osync(osync), .ohdr_err(ohdr_err), .ofrm_done(ofrm_done),
    .odecfail(odecfail), .obiterr(obiterr), .olen_err(olen_err)
  );

  always #5 iclk = ~iclk;

  // outputs change only on edges where iclkena was high; stretched pulses count once
  always @(posedge iclk) upd <= iclkena;

  always @(negedge iclk) begin
    if (upd && ireset) begin
      if (oval) bq.push_back({osop, oeop, odat});
      if (ofrm_done) fq.push_back({olen_err, odecfail, obiterr});
      if (ohdr_val) begin
        hdr_n++;
        hdr_cap = {ohdr_err, omatype, oupl, odfl, osync, osyncd};
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [71:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 71; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'hD5 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [79:0] mk_hdr(input logic [15:0] matype, upl, dfl,
                                         input logic [7:0] sync, input logic [15:0] syncd);
    logic [71:0] f;
    f = {matype, upl, dfl, sync, syncd};
    return {f, crc8_ref(f)};
  endfunction

  task automatic idle(input int n);
    iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    repeat (n) @(negedge iclk);
  endtask

  task automatic drive_bit(input logic sop, input logic eop, input logic d);
    int ng;
    if (gaps) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        iclkena = 1'($urandom_range(0, 1));
        ival    = iclkena ? 1'b0 : 1'($urandom_range(0, 1));
        isop = sop; ieop = eop; idat = d;
        @(negedge iclk);
      end
    end
    iclkena = 1'b1; ival = 1'b1; isop = sop; ieop = eop; idat = d;
    @(negedge iclk);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic send_frame(input logic [TW-1:0] tag, input logic [79:0] hdr,
                            input logic [127:0] pay, input int n, input int nsend,
                            input logic dec, input logic [15:0] be);
    int   total;
    logic b;
    total    = 80 + n;
    itag     = tag;
    idecfail = dec;
    ibiterr  = be;
    for (int i = 0; i < nsend; i++) begin
      if (i < 80) b = hdr[79-i];
      else        b = pay[127-(i-80)];
      drive_bit(i == 0, i == total - 1, b);
    end
  endtask

  task automatic clear_caps();
    bq.delete();
    fq.delete();
    hdr_n = 0;
  endtask

  task automatic check_bytes(input string tag, input logic [63:0] exp, input int n);
    logic [9:0] e;
    check({tag, "_nbytes"}, bq.size(), n);
    for (int i = 0; i < n; i++) begin
      e = {i == 0, i == n - 1, exp[63-8*i -: 8]};
      if (i < bq.size()) check($sformatf("%s_byte%0d", tag, i), bq[i], e);
    end
  endtask

  task automatic check_frm1(input string tag, input logic [17:0] exp);
    check({tag, "_nfrm"}, fq.size(), 1);
    if (fq.size() > 0) check({tag, "_frm"}, fq[0], exp);
  endtask

  logic [79:0]  h_good, h_bad, h_d12, h_d0;
  logic [127:0] pay_main;

  initial begin
    ireset = 1'b0; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
    idat = 1'b0; idecfail = 1'b0; ibiterr = '0; itag = '0;

    h_good   = mk_hdr(16'hF000, 16'h0000, 16'h0040, 8'h47, 16'h0000);
    h_bad    = h_good ^ 80'h1;
    h_d12    = mk_hdr(16'hF000, 16'h0000, 16'h000C, 8'h47, 16'h0000);
    h_d0     = mk_hdr(16'hF000, 16'h0000, 16'h0000, 8'h47, 16'h0000);
    pay_main = {64'h0123_4567_89AB_CDEF, 16'hA5A5, 48'h0};

    repeat (3) @(negedge iclk);
    check("reset_outputs", {osop, oval, oeop, odat, otag, ohdr_val, omatype, oupl, odfl,
                            osyncd, osync, ohdr_err, ofrm_done, odecfail, obiterr, olen_err}, '0);
    ireset = 1'b1;
    idle(2);

    // good header, 64 data bits, 16 pad bits
    clear_caps();
    send_frame(4'h1, h_good, pay_main, 80, 160, 1'b1, 16'h1234);
    idle(4);
    check("good_nhdr", hdr_n, 1);
    check("good_hdr", hdr_cap, {1'b0, 16'hF000, 16'h0000, 16'h0040, 8'h47, 16'h0000});
    check_bytes("good", 64'h0123_4567_89AB_CDEF, 8);
    check_frm1("good", {1'b0, 1'b1, 16'h1234});
    check("good_otag", otag, 4'h1);

    // CRC bit 79 flipped: header flagged, data discarded as padding
    clear_caps();
    send_frame(4'h2, h_bad, pay_main, 80, 160, 1'b0, 16'h0005);
    idle(4);
    check("crcbad_hdr_err", hdr_cap[72], 1'b1);
    check("crcbad_nbytes", bq.size(), 0);
    check_frm1("crcbad", {1'b0, 1'b0, 16'h0005});

    // DFL=12: second byte left-justified, pad bits not leaking in
    clear_caps();
    send_frame(4'h3, h_d12, {12'hABC, 4'hF, 112'h0}, 16, 96, 1'b0, 16'h0000);
    idle(4);
    check("dfl12_hdr", hdr_cap, {1'b0, 16'hF000, 16'h0000, 16'h000C, 8'h47, 16'h0000});
    check_bytes("dfl12", {16'hABC0, 48'h0}, 2);
    check_frm1("dfl12", {1'b0, 1'b0, 16'h0000});

    // ieop after 20 of 64 data bits: partial byte flushed, length error
    clear_caps();
    send_frame(4'h4, h_good, {20'h12345, 108'h0}, 20, 100, 1'b1, 16'h00FF);
    idle(4);
    check_bytes("short", {24'h123450, 40'h0}, 3);
    check_frm1("short", {1'b1, 1'b1, 16'h00FF});

    // isop at header bit 40 aborts frame A; frame B parses normally
    clear_caps();
    send_frame(4'h2, h_good, pay_main, 80, 40, 1'b1, 16'hFFFF);
    send_frame(4'h3, h_d12, {12'hABC, 4'hF, 112'h0}, 16, 96, 1'b0, 16'h0007);
    idle(4);
    check("abort_nfrm", fq.size(), 2);
    if (fq.size() > 1) begin
      check("abort_frmA", fq[0], {1'b1, 1'b0, 16'h0000});
      check("abort_frmB", fq[1], {1'b0, 1'b0, 16'h0007});
    end
    check("abort_nhdr", hdr_n, 1);
    check("abort_hdrB", hdr_cap, {1'b0, 16'hF000, 16'h0000, 16'h000C, 8'h47, 16'h0000});
    check_bytes("abortB", {16'hABC0, 48'h0}, 2);
    check("abort_otag", otag, 4'h3);

    // DFL=0 with good CRC: no data bytes
    clear_caps();
    send_frame(4'h6, h_d0, {8'hFF, 120'h0}, 8, 88, 1'b0, 16'h0000);
    idle(4);
    check("dfl0_nbytes", bq.size(), 0);
    check_frm1("dfl0", {1'b0, 1'b0, 16'h0000});

    // one-bit frame: isop and ieop together
    clear_caps();
    itag = 4'h5; idecfail = 1'b1; ibiterr = 16'h0009;
    drive_bit(1'b1, 1'b1, 1'b0);
    idle(4);
    check("onebit_nhdr", hdr_n, 0);
    check_frm1("onebit", {1'b1, 1'b1, 16'h0009});
    check("onebit_otag", otag, 4'h5);

    // same good frame with ival gaps and iclkena toggling
    clear_caps();
    gaps = 1'b1;
    send_frame(4'h1, h_good, pay_main, 80, 160, 1'b1, 16'h1234);
    gaps = 1'b0;
    idle(4);
    check("gaps_hdr", hdr_cap, {1'b0, 16'hF000, 16'h0000, 16'h0040, 8'h47, 16'h0000});
    check_bytes("gaps", 64'h0123_4567_89AB_CDEF, 8);
    check_frm1("gaps", {1'b0, 1'b1, 16'h1234});

    // reset in the middle of the data field
    clear_caps();
    gaps = 1'b1;
    send_frame(4'h7, h_good, pay_main, 80, 100, 1'b1, 16'h1234);
    gaps = 1'b0;
    ireset = 1'b0;
    idle(3);
    check("midrst_outputs", {osop, oval, oeop, odat, otag, ohdr_val, omatype, oupl, odfl,
                             osyncd, osync, ohdr_err, ofrm_done, odecfail, obiterr, olen_err}, '0);
    check("midrst_nfrm", fq.size(), 0);
    ireset = 1'b1;
    idle(2);
    clear_caps();
    send_frame(4'h6, h_d12, {12'hABC, 4'hF, 112'h0}, 16, 96, 1'b0, 16'h0000);
    idle(4);
    check("postrst_hdr", hdr_cap, {1'b0, 16'hF000, 16'h0000, 16'h000C, 8'h47, 16'h0000});
    check_bytes("postrst", {16'hABC0, 48'h0}, 2);
    check_frm1("postrst", {1'b0, 1'b0, 16'h0000});
    check("postrst_otag", otag, 4'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bch_dvb_bbh_unpack.md
# bch_dvb_bbh_unpack

Downstream stage of the DVB-S2/S2X BCH decoder. Consumes the decoder's serial corrected-data bit stream and parses the 80-bit BBHEADER, checking its CRC-8. It then packs the DFL data-field bits MSB-first into bytes and discards the padding. Per-frame decoder status (decfail, biterr) is forwarded with the frame-done strobe to the stream/TS adaptation layer.

## Interface
- pTAG_W, 1, width of the frame tag carried from isop to osop/ofrm_done.
- iclk  in  1  clock.
- ireset  in  1  reset, asynchronous, active-low.
- iclkena  in  1  clock enable; all state holds when 0.
- isop/ival/ieop  in  1 each  frame start / bit valid / last data bit (decoder osop/oval/oeop).
- itag  in  pTAG_W  tag, sampled with isop.
- idat  in  1  data bit, BBHEADER MSB first.
- idecfail  in  1  decoder fail flag, valid with ieop.
- ibiterr  in  16  corrected-bit count, valid with ieop.
- osop/oval/oeop  out  1 each  data-field byte framing.
- odat  out  8  data byte; first received bit is in bit 7.
- otag  out  pTAG_W  tag of the current frame.
- ohdr_val  out  1  one-cycle strobe: header fields are valid.
- omatype, oupl, odfl, osyncd  out  16 each  header fields.
- osync  out  8  SYNC field.
- ohdr_err  out  1  CRC-8 mismatch, valid with ohdr_val.
- ofrm_done  out  1  one-cycle end-of-frame strobe.
- odecfail  out  1  status, valid with ofrm_done.
- obiterr  out  16  status, valid with ofrm_done.
- olen_err  out  1  status, valid with ofrm_done.
- Reset values: all outputs 0.

## Operation
- States:
  - IDLE: wait for isop&ival.
  - HDR: collect 80 bits.
  - DATA: DFL bits.
  - PAD: discard until ieop.
- The isop bit is header bit 0. Field order: MATYPE[15:0], UPL, DFL, SYNC, SYNCD, CRC8.
- CRC-8: polynomial 0xD5 (x^8+x^7+x^6+x^4+x^2+1), init 0x00, serial over bits 0..71. Compare against bits 72..79.
- After bit 79:
  - ohdr_val is pulsed.
  - ohdr_err = CRC mismatch.
  - Next state: DATA if the CRC is good and DFL≠0, else PAD.
- DATA: 16-bit bit counter against DFL.
  - A byte is emitted every 8th bit.
  - osop marks the first byte, oeop the byte containing DFL bit DFL-1.
  - If DFL mod 8 ≠ 0, the last byte is left-justified and zero-filled, and emitted with oeop.
  - Then go to PAD, or directly to IDLE if this is the ieop bit.
- ieop is accepted in any non-IDLE state. On that bit:
  - Latch idecfail/ibiterr.
  - Pulse ofrm_done.
  - Return to IDLE.
- olen_err = 1 if ieop arrives in HDR, or in DATA before DFL is exhausted. If ieop arrives in DATA, any partial byte is flushed with oeop (plus osop if it is the first byte), zero-filled.
- isop in a non-IDLE state aborts the current frame:
  - An open byte stream is closed with a flushed oeop byte.
  - ofrm_done is pulsed with olen_err=1, odecfail=0, obiterr=0.
  - The new bit is taken as header bit 0 of the new frame.
- isop and ieop on the same bit (1-bit frame): treated as ieop in HDR, so olen_err=1.
- ival=0 cycles are ignored in every state. The bit counters do not wrap; DFL up to 0xFFFF is honoured.

## Timing
- All outputs are registered, 1-cycle latency from the enabling ival bit:
  - ohdr_val is high the cycle after bit 79.
  - oval is high the cycle after the 8th bit of a byte (or after the DFL-end/ieop bit).
  - ofrm_done is high the cycle after ieop.
- Header field registers and otag hold until the next ohdr_val/isop.
- oval, osop, oeop, ohdr_val and ofrm_done are single-cycle pulses. When iclkena=0 they are stretched, since outputs hold.
- ofrm_done may coincide with the final oval/oeop (ieop on the DFL-last bit).
- Throughput: 1 bit/cycle, no backpressure.
- Reset asserted mid-frame: return to IDLE immediately and clear all outputs. No flush, no ofrm_done.

## Structure
- Package bch_dvb_bbh_pkg holds:
  - the state enum;
  - field offsets (0,16,32,48,56,72);
  - cBBH_BITS=80;
  - cCRC8_POLY=8'hD5.
- Sub-module bch_dvb_crc8_serial: 1-bit/cycle CRC-8 with iclkena, init/val/dat inputs and a crc[7:0] output.
- Parent holds the FSM, the 80-bit header shift register, the DFL counter and the byte packer.

## Test plan
- Good header (MATYPE=0xF000, UPL=0, DFL=0x0040, SYNC=0x47, SYNCD=0, correct CRC) + 64 bits + 16 pad bits, ieop on the last:
  - ohdr_val=1 and ohdr_err=0, with all fields as sent;
  - 8 bytes, osop on the 1st, oeop on the 8th;
  - then ofrm_done with olen_err=0.
- Same header with CRC bit 79 flipped -> ohdr_err=1, no oval, ofrm_done with olen_err=0.
- DFL=0x000C (12 bits), data 0xABC -> bytes 0xAB then 0xC0 with oeop.
- DFL=0x0040, ieop after 20 data bits -> bytes 0xXX, 0xXX, then the 3rd byte flushed (4 bits + zeros) with oeop; olen_err=1.
- isop at header bit 40 of frame A -> frame A ofrm_done with olen_err=1; frame B parses normally with its own otag.
- ival gaps, iclkena toggling and reset asserted mid-DATA -> identical bytes to the gap-free run; after reset all outputs are 0 and the next isop parses cleanly.
